// File: rtl/t_stream_tx.sv
// t_stream_tx: transmit side of the toggle-coded serial link.
//
// The receiver is a plain toggle flop (q <= rs ? 0 : q ^ t). This block takes a
// DW-bit word over a valid/ready handshake. It drives t so that the receiver q
// walks through the frame: start level 1, the data bits LSB first, then stop
// level 0. The block keeps its own registered copy of the receiver flop (q_ref),
// so each t is the desired next level XOR the receiver q after the current edge.
//
// Ports
//   clk        in   1   clock, every state update on posedge
//   rs         in   1   synchronous active-high reset
//   din        in   DW  word to send, sampled only on acceptance
//   din_valid  in   1   producer has a word
//   din_ready  out  1   transmitter idle; accept = din_valid & din_ready
//   t          out  1   toggle command to the receiver flop (registered)
//   q_ref      out  1   cycle-exact model of the receiver q (registered)
//   busy       out  1   frame in progress (start, data or stop level on the line)
//   done       out  1   one-cycle pulse while the stop-bit toggle is driven
//
// Timing: acceptance at edge E0 gives receiver q=1 after E1 and q=bit i after
// E(2+i). It gives q=0 after E(DW+2), and din_ready returns after E(DW+2), so a
// frame occupies DW+3 cycles when words are sent back to back.

module t_stream_tx #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rs,
   input  logic [DW-1:0] din,
   input  logic          din_valid,
   output logic          din_ready,
   output logic          t,
   output logic          q_ref,
   output logic          busy,
   output logic          done
);

   // Bit counter is at least one bit wide so DW=1 still has a legal vector.
   localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(DW - 1);

   // The state names what t is driving during the current cycle.
   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [DW-1:0] shreg;

   // Receiver q just after the coming edge; toggling against it yields level L.
   logic qn;
   logic accept;

   assign qn     = q_ref ^ t;
   assign accept = din_valid & din_ready;

   always_ff @(posedge clk) begin
      if (rs) begin
         state     <= StIdle;
         t         <= 1'b0;
         q_ref     <= 1'b0;
         din_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cnt       <= '0;
         shreg     <= '0;
      end else begin
         q_ref <= qn;
         unique case (state)
            StIdle: begin
               // Hold the line level: L = qn, so t = 0.
               t         <= 1'b0;
               din_ready <= 1'b1;
               if (accept) begin
                  shreg     <= din;
                  t         <= ~qn;           // start level 1
                  din_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= StStart;
               end
            end
            StStart: begin
               t     <= shreg[0] ^ qn;        // data bit 0
               shreg <= shreg >> 1;
               cnt   <= '0;
               state <= StData;
            end
            StData: begin
               if (cnt != LastCnt) begin
                  t     <= shreg[0] ^ qn;     // data bit cnt+1
                  shreg <= shreg >> 1;
                  cnt   <= cnt + CW'(1);
               end else begin
                  t     <= qn;                // stop level 0
                  done  <= 1'b1;
                  state <= StStop;
               end
            end
            StStop: begin
               // The line is at 0 after this edge, so idle needs no toggle.
               t         <= 1'b0;
               done      <= 1'b0;
               busy      <= 1'b0;
               din_ready <= 1'b1;
               state     <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
